uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmit byte port (uart_tx_data/uart_tx_start/uart_tx_busy) of the

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one UART transmit byte port
// Optional lock timeout: define UART_TX_ARB_TIMEOUT_EN (adds LOCK_TIMEOUT parameter).
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 4
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int LOCK_TIMEOUT = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_start,
    input  logic                 uart_tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout_pulse
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WC_W  = $clog2(BUSY_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_RISE,
        S_WAIT_FALL
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  pick;
    logic [PTR_W-1:0]  next_ptr;
    logic              pick_ok;
    logic              last_q;
    logic [WC_W-1:0]   wait_cnt;
    logic [7:0]        owner_data;
    logic              owner_valid;
    logic              owner_last;

    // First valid requester at or after the round-robin pointer, wrapping
    always_comb begin
        int j;
        j       = 0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_ok && req_valid[j[PTR_W-1:0]]) begin
                pick_ok = 1'b1;
                pick    = j[PTR_W-1:0];
            end
        end
    end

    // Select the current owner's byte, valid and last flag
    always_comb begin
        owner_data  = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner == k[PTR_W-1:0]) begin
                owner_data  = req_data[8*k +: 8];
                owner_valid = req_valid[k];
                owner_last  = req_last[k];
            end
        end
    end

    // The released owner becomes lowest priority on the next arbitration
    assign next_ptr  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    assign req_ready = (state == S_LOAD) ? (req_valid & grant) : '0;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_pulse = 1'b0;
`endif

    // Arbitration and byte pacing state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            grant         <= '0;
            last_q        <= 1'b0;
            uart_tx_data  <= '0;
            uart_tx_start <= 1'b0;
            wait_cnt      <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
            uart_tx_start <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (pick_ok && !uart_tx_busy) begin
                        owner <= pick;
                        grant <= NUM_REQ'(1) << pick;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (owner_valid) begin
                        uart_tx_data  <= owner_data;
                        last_q        <= owner_last;
                        uart_tx_start <= 1'b1;
                        state         <= S_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        to_cnt        <= '0;
                    end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                        // Owner stalled too long mid-packet: force release
                        grant         <= '0;
                        rr_ptr        <= next_ptr;
                        timeout_pulse <= 1'b1;
                        to_cnt        <= '0;
                        state         <= S_IDLE;
                    end else begin
                        to_cnt        <= to_cnt + 1'b1;
`endif
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT_RISE;
                end
                S_WAIT_RISE: begin
                    if (uart_tx_busy || wait_cnt == WC_W'(BUSY_WAIT - 1)) begin
                        state <= S_WAIT_FALL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WAIT_FALL: begin
                    if (!uart_tx_busy) begin
                        if (last_q) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= S_IDLE;
                        end else begin
                            state  <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_start;
    logic           uart_tx_busy = 1'b0;
    logic [N-1:0]   grant;
    logic           timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .BUSY_WAIT(BW)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .LOCK_TIMEOUT(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .uart_tx_data(uart_tx_data),
        .uart_tx_start(uart_tx_start),
        .uart_tx_busy(uart_tx_busy),
        .grant(grant),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endfunction

    // Requester packet stores: {last, byte}
    logic [8:0] rmem [N][16];
    int         rhead [N];
    int         rtail [N];

    task automatic push_byte(input int r, input logic [7:0] b, input logic l);
        rmem[r][rtail[r]] = {l, b};
        rtail[r]++;
    endtask

    // Expected transmit order, from the round-robin-with-lock rule
    int         exp_owner [$];
    logic [7:0] exp_byte [$];
    int         obs_owner [$];
    logic [7:0] obs_byte [$];
    int         obs_cyc [$];
    int         pulse_cnt = 0;

    task automatic build_expect();
        int h [N];
        int ptr;
        int sel;
        bit done;
        bit fin;
        ptr  = 0;
        done = 1'b0;
        for (int i = 0; i < N; i++) h[i] = rhead[i];
        exp_owner.delete();
        exp_byte.delete();
        while (!done) begin
            sel = -1;
            for (int k = 0; k < N; k++) begin
                if (sel < 0 && h[(ptr + k) % N] < rtail[(ptr + k) % N]) sel = (ptr + k) % N;
            end
            if (sel < 0) begin
                done = 1'b1;
            end else begin
                fin = 1'b0;
                while (!fin && h[sel] < rtail[sel]) begin
                    exp_owner.push_back(sel);
                    exp_byte.push_back(rmem[sel][h[sel]][7:0]);
                    fin = rmem[sel][h[sel]][8];
                    h[sel]++;
                end
                if (!fin) begin
`ifndef UART_TX_ARB_TIMEOUT_EN
                    done = 1'b1;
`endif
                end
                ptr = (sel + 1) % N;
            end
        end
    endtask

    // Environment: requesters pop on handshake, UART busy model reacts to start
    int         rise_len = 2;
    int         hold_len = 6;
    int         rise_cnt = 0;
    int         hold_cnt = 0;
    bit         busy_tie0 = 1'b0;
    logic [N-1:0] hs;

    initial begin
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                uart_tx_busy = 1'b0;
                rise_cnt     = 0;
                hold_cnt     = 0;
            end else begin
                for (int i = 0; i < N; i++) if (hs[i]) rhead[i]++;
                if (busy_tie0) begin
                    uart_tx_busy = 1'b0;
                end else begin
                    if (rise_cnt > 0) begin
                        rise_cnt--;
                        if (rise_cnt == 0) begin
                            uart_tx_busy = 1'b1;
                            hold_cnt     = hold_len;
                        end
                    end else if (uart_tx_busy) begin
                        hold_cnt--;
                        if (hold_cnt == 0) uart_tx_busy = 1'b0;
                    end
                    if (uart_tx_start) rise_cnt = rise_len;
                end
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (rhead[i] < rtail[i]);
                if (req_valid[i]) {req_last[i], req_data[8*i +: 8]} = rmem[i][rhead[i]];
                else {req_last[i], req_data[8*i +: 8]} = 9'h0;
            end
        end
    end

    // Per-cycle compare against the model and the port rules
    logic prev_start = 1'b0;
    int   owner_idx;

    always @(negedge clk) begin
        if (!rst) begin
            check("ready_onehot0", $countones(req_ready) <= 1, 1);
            check("grant_onehot0", $countones(grant) <= 1, 1);
            check("ready_not_owner", req_ready & ~grant, 0);
            if (uart_tx_start) begin
                check("start_width", prev_start, 0);
                check("start_while_busy", uart_tx_busy, 0);
                owner_idx = -1;
                for (int i = 0; i < N; i++) if (grant[i]) owner_idx = i;
                obs_owner.push_back(owner_idx);
                obs_byte.push_back(uart_tx_data);
                obs_cyc.push_back(cyc);
                if (exp_byte.size() == 0) begin
                    check("sb_extra_start", 1, 0);
                end else begin
                    check("sb_byte", uart_tx_data, exp_byte.pop_front());
                    check("sb_owner", owner_idx, exp_owner.pop_front());
                end
            end
            if (timeout_pulse) pulse_cnt++;
`ifndef UART_TX_ARB_TIMEOUT_EN
            check("timeout_tied0", timeout_pulse, 0);
`endif
        end
        prev_start = uart_tx_start;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        obs_owner.delete();
        obs_byte.delete();
        obs_cyc.delete();
        exp_owner.delete();
        exp_byte.delete();
        pulse_cnt = 0;
        busy_tie0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_byte.size() != 0 || grant != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, n < budget, 1);
    endtask

    task automatic wait_starts(input string name, input int cnt, input int budget);
        int n;
        n = 0;
        while (obs_cyc.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_starts"}, n < budget, 1);
    endtask

    task automatic first_zero_grant(output int c, input int budget);
        int n;
        n = 0;
        while (grant != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        check("grant_release_bound", n < budget, 1);
    endtask

    int t0;
    int s0;
    int c;
    int n;
    int t4_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] t3_bytes [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    int t3_owner [4] = '{1, 1, 1, 2};

    initial begin
        // T1: reset with all requesters valid
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        for (int i = 0; i < N; i++) push_byte(i, 8'h80 + 8'(i), 1'b1);
        build_expect();
        @(negedge clk);
        @(negedge clk);
        check("t1_rst_grant", grant, 0);
        check("t1_rst_ready", req_ready, 0);
        check("t1_rst_start", uart_tx_start, 0);
        check("t1_rst_data", uart_tx_data, 0);
        check("t1_rst_timeout", timeout_pulse, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t1_grant", grant, 4'b0001);
        check("t1_ready", req_ready, 4'b0001);
        check("t1_start_low", uart_tx_start, 0);
        @(negedge clk);
        check("t1_start", uart_tx_start, 1);
        check("t1_data", uart_tx_data, 8'h80);
        wait_drain("t1", 300);
        check("t1_count", obs_owner.size(), 4);
        for (int i = 0; i < 4 && i < obs_owner.size(); i++) check("t1_order", obs_owner[i], i);

        // T2: single byte, busy rises 2 cycles after start and holds 10
        do_reset();
        rise_len = 2;
        hold_len = 10;
        push_byte(0, 8'h55, 1'b1);
        build_expect();
        t0 = cyc;
        wait_starts("t2", 1, 20);
        s0 = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
        check("t2_start_latency", s0, t0 + 3);
        first_zero_grant(c, 40);
        check("t2_release_cycle", c, s0 + 13);
        wait_drain("t2", 40);
        check("t2_one_start", obs_cyc.size(), 1);
        check("t2_data_held", uart_tx_data, 8'h55);

        // T3: packet lock holds off a competing requester
        do_reset();
        rise_len = 1;
        hold_len = 5;
        push_byte(1, 8'hA1, 1'b0);
        push_byte(1, 8'hA2, 1'b0);
        push_byte(1, 8'hA3, 1'b1);
        push_byte(2, 8'hB0, 1'b1);
        build_expect();
        wait_drain("t3", 200);
        check("t3_count", obs_byte.size(), 4);
        for (int i = 0; i < 4 && i < obs_byte.size(); i++) begin
            check("t3_byte", obs_byte[i], t3_bytes[i]);
            check("t3_owner", obs_owner[i], t3_owner[i]);
        end

        // T4: round-robin with all requesters continuously valid
        do_reset();
        rise_len = 2;
        hold_len = 6;
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < N; i++) push_byte(i, 8'h40 + 8'(16 * rep + i), 1'b1);
        build_expect();
        wait_drain("t4", 400);
        check("t4_count", obs_owner.size(), 8);
        for (int i = 0; i < 6 && i < obs_owner.size(); i++) check("t4_order", obs_owner[i], t4_order[i]);

        // T5: busy never rises, each byte ends BUSY_WAIT+1 cycles after its start
        do_reset();
        busy_tie0 = 1'b1;
        push_byte(3, 8'h31, 1'b0);
        push_byte(3, 8'h32, 1'b0);
        push_byte(3, 8'h33, 1'b1);
        build_expect();
        wait_starts("t5", 3, 60);
        first_zero_grant(c, 30);
        if (obs_cyc.size() >= 3) begin
            check("t5_gap0", obs_cyc[1] - obs_cyc[0], BW + 3);
            check("t5_gap1", obs_cyc[2] - obs_cyc[1], BW + 3);
            check("t5_release", c, obs_cyc[2] + BW + 2);
        end
        wait_drain("t5", 40);

        // T6: owner stalls mid-packet
        do_reset();
        busy_tie0 = 1'b1;
        push_byte(0, 8'h10, 1'b0);
        push_byte(1, 8'h20, 1'b1);
        build_expect();
        wait_starts("t6", 1, 20);
        s0 = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        n = 0;
        while (timeout_pulse !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_pulse_seen", n < 100, 1);
        check("t6_pulse_cycle", cyc, s0 + BW + 2 + 16);
        @(negedge clk);
        check("t6_pulse_width", timeout_pulse, 0);
        check("t6_grant_req1", grant, 4'b0010);
        wait_drain("t6", 60);
        check("t6_pulse_count", pulse_cnt, 1);
        check("t6_count", obs_owner.size(), 2);
        if (obs_owner.size() >= 2) check("t6_second_owner", obs_owner[1], 1);
`else
        repeat (80) @(negedge clk);
        check("t6_lock_held", grant, 4'b0001);
        check("t6_one_start", obs_cyc.size(), 1);
        check("t6_no_ready", req_ready, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach summary");
        $fatal(1);
    end

endmodule
